// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe : registered, valid/ready handshaked ALU with a persistent carry.
//
// Sits between operand fetch and writeback. Single-cycle ops load the output
// register on acceptance. Optional iterative shift-add multiplier (opcode 14)
// is compiled in when the macro ALU_PIPE_MUL_EN is defined. Without it,
// opcode 14 is illegal.
//
// Parameters:
//   WIDTH         datapath width (power of two, >= 8)
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   in_valid_i    operation presented
//   in_ready_o    operation accepted this cycle (combinational)
//   in_op_i       4-bit opcode
//   in_a_i/in_b_i operands; shifts use in_b_i[SHW-1:0] as the amount
//   out_valid_o   result held in the output register
//   out_ready_i   consumer takes the result
//   out_result_o  result
//   out_flags_o   {Z,N,C,V} for this result
//   out_err_o     illegal opcode flag
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_op_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic [3:0]       out_flags_o,
  output logic             out_err_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4,  OP_DEC = 4'd5,  OP_PASS = 4'd6, OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8,  OP_XOR = 4'd9,  OP_NOT = 4'd10, OP_SLL = 4'd11;
  localparam logic [3:0] OP_SRL = 4'd12, OP_SRA = 4'd13, OP_MUL = 4'd14;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  // Signed overflow of an add: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a subtract: operands differ in sign, result differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {(r == {WIDTH{1'b0}}), r[WIDTH-1], c, v};
  endfunction

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             carry_q, carry_d;

  logic             accept_s, load_s, start_mul_s, is_mul_s, mul_last_s;
  logic [WIDTH:0]   ext_s;
  logic [SHW-1:0]   amt_s;
  logic [WIDTH-1:0] alu_res_s, mul_res_s;
  logic             alu_c_s, alu_v_s, alu_err_s, mul_c_s;

  assign in_ready_o = (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
  assign accept_s   = in_valid_i && in_ready_o;
  assign amt_s      = in_b_i[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  assign is_mul_s   = (in_op_i == OP_MUL);
  assign mul_last_s = (state_q == S_MUL) && (cnt_q == SHW'(WIDTH - 1));
  assign mul_res_s  = acc_q[WIDTH-1:0];
  assign mul_c_s    = |acc_q[2*WIDTH-1:WIDTH];

  // Multiplier next state: load operands on start, one shift-add step per MUL cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_mul_s) begin
      acc_d    = {(2*WIDTH){1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, in_a_i};
      mplier_d = in_b_i;
      cnt_d    = {SHW{1'b0}};
    end else if (state_q == S_MUL) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SHW'(1);
    end else begin
      acc_d    = acc_q;
    end
  end

  // Multiplier partial-product registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign is_mul_s   = 1'b0;
  assign mul_last_s = 1'b0;
  assign mul_res_s  = {WIDTH{1'b0}};
  assign mul_c_s    = 1'b0;
`endif

  // Single-cycle ALU: result, post-update carry, overflow and illegal flag.
  always_comb begin
    ext_s     = {(WIDTH+1){1'b0}};
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = carry_q;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (in_op_i)
      OP_ADD, OP_ADC, OP_INC: begin
        // ext_s[WIDTH] is the carry-out; INC adds a constant 1 with msb 0.
        if (in_op_i == OP_INC) begin
          ext_s   = {1'b0, in_a_i} + {{WIDTH{1'b0}}, 1'b1};
          alu_v_s = add_ovf(in_a_i[WIDTH-1], 1'b0, ext_s[WIDTH-1]);
        end else begin
          ext_s   = {1'b0, in_a_i} + {1'b0, in_b_i}
                  + {{WIDTH{1'b0}}, (in_op_i == OP_ADC) & carry_q};
          alu_v_s = add_ovf(in_a_i[WIDTH-1], in_b_i[WIDTH-1], ext_s[WIDTH-1]);
        end
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
      end
      OP_SUB, OP_SBB, OP_DEC: begin
        // A negative (WIDTH+1)-bit difference sets the top bit: that is the borrow.
        if (in_op_i == OP_DEC) begin
          ext_s   = {1'b0, in_a_i} - {{WIDTH{1'b0}}, 1'b1};
          alu_v_s = sub_ovf(in_a_i[WIDTH-1], 1'b0, ext_s[WIDTH-1]);
        end else begin
          ext_s   = {1'b0, in_a_i} - {1'b0, in_b_i}
                  - {{WIDTH{1'b0}}, (in_op_i == OP_SBB) & carry_q};
          alu_v_s = sub_ovf(in_a_i[WIDTH-1], in_b_i[WIDTH-1], ext_s[WIDTH-1]);
        end
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
      end
      OP_PASS: alu_res_s = in_a_i;
      OP_AND:  alu_res_s = in_a_i & in_b_i;
      OP_OR:   alu_res_s = in_a_i | in_b_i;
      OP_XOR:  alu_res_s = in_a_i ^ in_b_i;
      OP_NOT:  alu_res_s = ~in_a_i;
      // Shifts run on a WIDTH+1 vector so the guard bit holds the last bit shifted out
      // (and stays 0 for a zero amount).
      OP_SLL: begin
        ext_s     = {1'b0, in_a_i} << amt_s;
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
      end
      OP_SRL: begin
        ext_s     = {in_a_i, 1'b0} >> amt_s;
        alu_res_s = ext_s[WIDTH:1];
        alu_c_s   = ext_s[0];
      end
      OP_SRA: begin
        ext_s     = $signed({in_a_i, 1'b0}) >>> amt_s;
        alu_res_s = ext_s[WIDTH:1];
        alu_c_s   = ext_s[0];
      end
`ifdef ALU_PIPE_MUL_EN
      // Handled by the iterative multiplier; nothing loads from here.
      OP_MUL: alu_res_s = {WIDTH{1'b0}};
`endif
      default: alu_err_s = 1'b1;
    endcase
  end

  // Control FSM: next state, output-register load and multiplier start.
  always_comb begin
    state_d     = state_q;
    load_s      = 1'b0;
    start_mul_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_d     = S_MUL;
          start_mul_s = 1'b1;
        end else if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        if (!out_valid_q || out_ready_i) begin
          load_s  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register and carry next state.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    err_d       = err_q;
    carry_d     = carry_q;
    if (load_s && (state_q == S_DONE)) begin
      out_valid_d = 1'b1;
      res_d       = mul_res_s;
      carry_d     = mul_c_s;
      flags_d     = pack_flags(mul_res_s, mul_c_s, 1'b0);
      err_d       = 1'b0;
    end else if (load_s) begin
      out_valid_d = 1'b1;
      res_d       = alu_res_s;
      carry_d     = alu_c_s;
      flags_d     = pack_flags(alu_res_s, alu_c_s, alu_v_s);
      err_d       = alu_err_s;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State, carry and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= {WIDTH{1'b0}};
      flags_q     <= 4'd0;
      err_q       <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_result_o = res_q;
  assign out_flags_o  = flags_q;
  assign out_err_o    = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed literal checks from the
// test plan, then randomized traffic scored against a behavioural model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        out_err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_flags_o(out_flags), .out_err_o(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic mcarry = 1'b0;

  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [3:0] f, output logic e);
    logic [63:0] ua, ub, mc, t;
    longint sa, sb, sc, sx;
    logic c, v, arith;
    int n;
    ua = {32'd0, a}; ub = {32'd0, b}; mc = {63'd0, mcarry};
    sa = longint'($signed(a)); sb = longint'($signed(b)); sc = longint'(mc);
    n = int'(b[4:0]);
    c = mcarry; v = 1'b0; e = 1'b0; r = 32'd0; arith = 1'b0; sx = 0; t = 64'd0;
    case (op)
      4'd0: begin t = ua + ub;      c = t[32];         sx = sa + sb;      arith = 1'b1; end
      4'd1: begin t = ua + ub + mc; c = t[32];         sx = sa + sb + sc; arith = 1'b1; end
      4'd2: begin t = ua - ub;      c = (ua < ub);     sx = sa - sb;      arith = 1'b1; end
      4'd3: begin t = ua - ub - mc; c = (ua < ub + mc); sx = sa - sb - sc; arith = 1'b1; end
      4'd4: begin t = ua + 64'd1;   c = t[32];         sx = sa + 1;       arith = 1'b1; end
      4'd5: begin t = ua - 64'd1;   c = (ua < 64'd1);  sx = sa - 1;       arith = 1'b1; end
      4'd6: r = a;
      4'd7: r = a & b;
      4'd8: r = a | b;
      4'd9: r = a ^ b;
      4'd10: r = ~a;
      4'd11: begin t = ua << n; r = t[31:0]; c = t[32]; end
      4'd12: begin r = a >> n; t = (n == 0) ? 64'd0 : (ua >> (n - 1)); c = t[0]; end
      4'd13: begin r = 32'($signed(a) >>> n); t = (n == 0) ? 64'd0 : (ua >> (n - 1)); c = t[0]; end
`ifdef ALU_PIPE_MUL_EN
      4'd14: begin t = ua * ub; r = t[31:0]; c = (t[63:32] != 32'd0); end
`endif
      default: e = 1'b1;
    endcase
    if (arith) begin
      r = t[31:0];
      v = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
    end
    f = {(r == 32'd0), r[31], c, v};
    mcarry = c;
  endfunction

  // ---------------- compare process ----------------
  typedef struct packed { logic [31:0] r; logic [3:0] f; logic e; } exp_t;
  exp_t exp_q[$];
  logic        have_hold = 1'b0;
  logic [36:0] hold_v;
  logic        want_valid = 1'b0;

  always @(negedge clk) begin
    exp_t x;
    logic [31:0] r; logic [3:0] f; logic e;
    if (!rst_n) begin
      exp_q.delete(); mcarry = 1'b0; have_hold = 1'b0; want_valid = 1'b0;
    end else begin
      if (want_valid) chk("latency1 out_valid", out_valid, 1);
      want_valid = 1'b0;
      if (have_hold) begin
        chk("stall out_valid", out_valid, 1);
        chk("stall stable", {out_result, out_flags, out_err}, hold_v);
      end
      if (out_valid && !out_ready) begin
        chk("backpressure in_ready", in_ready, 0);
        have_hold = 1'b1; hold_v = {out_result, out_flags, out_err};
      end else begin
        have_hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected output", 1, 0);
        end else begin
          x = exp_q.pop_front();
          chk("result", out_result, x.r);
          chk("flags", out_flags, x.f);
          chk("err", out_err, x.e);
        end
      end
      if (in_valid && in_ready) begin
        model_op(in_op, in_a, in_b, r, f, e);
        exp_q.push_back('{r: r, f: f, e: e});
`ifdef ALU_PIPE_MUL_EN
        want_valid = (in_op != 4'd14);
`else
        want_valid = 1'b1;
`endif
      end
    end
  end

  // ---------------- directed helper ----------------
  task automatic op_check(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                          input logic ee);
    int g;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 4'($urandom);
    g = 0;
    while (!out_valid && g < 200) begin @(posedge clk); #1; g++; end
    chk({name, " wait"}, (g < 200), 1);
    chk({name, " result"}, out_result, er);
    chk({name, " flags"}, out_flags, ef);
    chk({name, " err"}, out_err, ee);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int g, k;
    logic saw_ready;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset result", out_result, 0);
    chk("reset flags", out_flags, 0);
    chk("reset err", out_err, 0);
    chk("reset in_ready", in_ready, 1);

    // flags are {Z,N,C,V}
    op_check("ADD wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1010, 1'b0);
    op_check("ADC chain", 4'd1, 32'd5, 32'd6, 32'd12, 4'b0000, 1'b0);
    op_check("SUB neg", 4'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0110, 1'b0);
    op_check("SBB chain", 4'd3, 32'd10, 32'd2, 32'd7, 4'b0000, 1'b0);
    op_check("ADD ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0101, 1'b0);
    op_check("SRA 4", 4'd13, 32'h8000_0010, 32'd4, 32'hF800_0001, 4'b0100, 1'b0);
    op_check("SLL 1", 4'd11, 32'h8000_0001, 32'd1, 32'h0000_0002, 4'b0010, 1'b0);
    op_check("SLL 32", 4'd11, 32'h8000_0001, 32'd32, 32'h8000_0001, 4'b0100, 1'b0);
    op_check("SUB set C", 4'd2, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b0110, 1'b0);
    op_check("illegal 15", 4'd15, 32'h1234, 32'h5678, 32'd0, 4'b1010, 1'b1);
    op_check("ADC after illegal", 4'd1, 32'd1, 32'd1, 32'd3, 4'b0000, 1'b0);
`ifdef ALU_PIPE_MUL_EN
    op_check("MUL hi", 4'd14, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b1010, 1'b0);
    // latency: accepted at edge N, out_valid after edge N+33
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'd14; in_a = 32'd3; in_b = 32'd7;
    g = 0;
    while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0; saw_ready = 1'b0;
    while (!out_valid && k < 200) begin
      saw_ready = saw_ready | in_ready;
      @(posedge clk); #1; k++;
    end
    chk("MUL latency", k, 33);
    chk("MUL in_ready low", saw_ready, 0);
    chk("MUL 3*7", out_result, 32'd21);
    // reset in the middle of a multiply
    op_check("SUB set C2", 4'd2, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b0110, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'd14; in_a = 32'h0001_0000; in_b = 32'h0001_0000;
    g = 0;
    while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    k = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) k++; end
    chk("abort no output", k, 0);
    op_check("ADC after abort", 4'd1, 32'd0, 32'd0, 32'd0, 4'b1000, 1'b0);
`else
    op_check("op14 illegal", 4'd14, 32'd9, 32'd9, 32'd0, 4'b1000, 1'b1);
`endif

    // randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      in_a      = pick();
      in_b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : pick();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 500) begin @(posedge clk); #1; g++; end
    chk("drain empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, handshaked successor to the combinational ALU. It is generalised to a `WIDTH`-bit datapath and adds a persistent carry flag that chains ADC/SBB across operations, variable shift amounts, and status flags. An optional iterative multiplier can be compiled in. It sits between the operand-fetch stage and writeback, using valid/ready on both sides.

## Interface
- `WIDTH`, 32, datapath width; a power of two, ≥ 8. `SHW = $clog2(WIDTH)`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block accepts the operation this cycle
- `in_op`  in  4  opcode (see Operation)
- `in_a`, `in_b`  in  WIDTH  operands; shifts use `in_b[SHW-1:0]` as the amount
- `out_valid`  out  1  result held in the output register
- `out_ready`  in  1  consumer takes the result
- `out_result`  out  WIDTH  result
- `out_flags`  out  4  {Z,N,C,V} for this result
- `out_err`  out  1  illegal opcode flag

## Operation
- Opcodes:
  - 0 ADD a+b; 1 ADC a+b+C; 2 SUB a-b; 3 SBB a-b-C; 4 INC a+1; 5 DEC a-1; 6 PASS a.
  - 7 AND; 8 OR; 9 XOR; 10 NOT a.
  - 11 SLL; 12 SRL; 13 SRA (shifts by `b[SHW-1:0]`).
  - 14 MUL (macro only); 15 illegal.
- The carry register C is internal and persistent.
  - Opcodes 0–5 update C: carry-out for add-type ops, borrow (unsigned a<b, including the borrow-in) for subtract-type ops.
  - Shifts set C to the last bit shifted out, or 0 when the amount is 0.
  - Logic ops and PASS leave C unchanged.
- ADC and SBB read C as updated by the most recently accepted operation, so back-to-back chaining is valid.
- V is signed overflow for opcodes 0–5 and 0 otherwise. Z = (result==0). N = result[WIDTH-1]. The C field of `out_flags` is the post-update C.
- Illegal opcode (15, and 14 without the macro):
  - `out_result` = 0, `out_err` = 1;
  - Z=1, N=0, V=0, C field reports C;
  - C is unchanged.
- The FSM has states IDLE, MUL, DONE.
  - IDLE: single-cycle ops load the output register on acceptance. An accepted MUL goes to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles, then DONE.
  - DONE: loads the output register once `!out_valid || out_ready`, then returns to IDLE.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`. It is combinational and has no dependency on `in_valid`.
- Inputs are sampled only on acceptance (`in_valid && in_ready`). They may change freely after acceptance.
- `out_result`, `out_flags` and `out_err` stay stable while `out_valid && !out_ready`.

## Timing
- Reset, asynchronous: `out_valid`=0, `out_result`=0, `out_flags`=0, `out_err`=0, C=0, state=IDLE. `in_ready` reads 1 after reset.
- Assertion of `rst_n` mid-multiply aborts the operation with no output.
- Single-cycle ops: accepted at edge N, `out_valid` high after edge N, i.e. latency 1.
- Full throughput of one op per cycle is sustained when `out_ready` is held high.
- Simultaneous consume and accept in one cycle: the output register is replaced by the new result and `out_valid` stays 1.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and no op is accepted.
- MUL: accepted at edge N, `out_valid` rises after edge N+WIDTH+1 if unstalled. `in_ready`=0 throughout MUL and DONE.
- Shift amount is taken modulo WIDTH (low SHW bits only). SRA replicates a[WIDTH-1].

## Configuration
- `ALU_PIPE_MUL_EN` defined:
  - Opcode 14 is an unsigned shift-add multiply. The result is the low WIDTH bits of a*b.
  - C = 1 iff the high WIDTH bits are nonzero (C register updated); V=0.
  - MUL/DONE states and the partial-product registers are present.
- Undefined:
  - Opcode 14 is illegal (`out_err`=1, result 0).
  - The FSM never leaves IDLE and no multiplier logic is built.

## Test plan
- Reset then ADD 0xFFFFFFFF+0x00000001 -> result 0, Z=1, C=1, V=0; next ADC 5+6 -> 12, C=0.
- SUB 3-5 -> 0xFFFFFFFE, N=1, C=1; then SBB 10-2 -> 7, C=0; ADD 0x7FFFFFFF+1 -> 0x80000000, V=1.
- SRA 0x80000010 by b=4 -> 0xF8000001, C=0; SLL 0x80000001 by 1 -> 0x00000002, C=1; SLL by b=32 -> shift of 0, C=0.
- Opcode 15 -> `out_err`=1, result 0; C from previous op retained and visible in next ADC.
- Backpressure: hold `out_ready`=0 for 3 cycles after a result -> `in_ready`=0, outputs stable; release -> resume at one op per cycle with no op lost or duplicated.
- With `ALU_PIPE_MUL_EN`: MUL 0x10000*0x10000 -> result 0, C=1, `out_valid` exactly 33 cycles after acceptance (WIDTH=32). Repeat with `rst_n` pulsed at cycle 10 -> no output, state IDLE, C=0.
